prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, giving the instruction-memory word-address width (depth 2^ADDR_W words).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port rx_valid  input  1  byte-stream valid.
REQ-005 SHALL have port rx_data  input  8  program byte.
REQ-006 SHALL have port rx_last  input  1  marks the final program byte; sampled only with rx_valid.
REQ-007 SHALL have port rx_ready  output  1  byte accepted when rx_valid and rx_ready are both high on a clock edge.
REQ-008 SHALL have port imem_we  output  1  instruction-memory write strobe.
REQ-009 SHALL have port imem_addr  output  ADDR_W  instruction-memory word address.
REQ-010 SHALL have port imem_wdata  output  32  instruction word to write.
REQ-011 SHALL have port start  output  1  processor run enable; drives the processor start input.
REQ-012 SHALL have port busy  output  1  loader is in LOAD or WRITE.
REQ-013 SHALL have port word_count  output  ADDR_W+1  number of words written since reset.
REQ-014 SHALL have port overflow  output  1  program exceeded memory depth.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, WRITE, RUN, ERR.
REQ-016 SHALL go IDLE->LOAD on the first accepted byte; LOAD->WRITE when a 4th byte is accepted or a byte with rx_last is accepted; WRITE->LOAD after one cycle, or WRITE->RUN if the word held rx_last.
REQ-017 SHALL pack bytes little-endian: byte k of a word (k=0..3, k = 2-bit byte counter) goes to bits [8k+7:8k].
REQ-018 SHALL zero-fill the unreceived upper bytes of a word closed early by rx_last.
REQ-019 SHALL assert imem_we for exactly the one WRITE cycle, the cycle after the closing byte is accepted; imem_addr = word_count[ADDR_W-1:0] and imem_wdata = assembled word in that cycle.
REQ-020 SHALL increment word_count on the edge ending WRITE and clear the byte assembly register and byte counter at that edge.
REQ-021 SHALL drive rx_ready high in IDLE and LOAD and low in WRITE, RUN and ERR; a byte held on rx_valid during WRITE SHALL be accepted in the following LOAD cycle, never lost or duplicated.
REQ-022 SHALL assert start on the first cycle of RUN and hold it high until reset; imem_we SHALL be low in RUN.
REQ-023 SHALL ignore all bytes in RUN; no further writes occur.
REQ-024 SHALL enter ERR, not write, and set overflow when a byte is accepted while word_count == 2^ADDR_W.
REQ-025 SHALL hold ERR (start low, overflow high, rx_ready low) until reset.
REQ-026 SHALL drive busy = 1 exactly in LOAD and WRITE.
REQ-027 SHALL keep imem_addr and imem_wdata at 0 whenever imem_we is low.

Reset
REQ-028 SHALL on reset low, immediately and independent of clk: enter IDLE; set start, imem_we, busy, overflow to 0; set word_count, imem_addr, imem_wdata, byte counter and assembly register to 0; set rx_ready to 1.
REQ-029 SHALL treat reset asserted mid-LOAD or mid-WRITE the same way, discarding any partial word; already-written memory is not cleared.
REQ-030 SHALL leave reset on the first rising clk edge after reset goes high, with state IDLE.

Verification
REQ-031 Bytes 01..08, rx_last on 08, no gaps -> imem_we writes 0x04030201@0, then 0x08070605@1; start high the cycle after the second write; word_count=2.
REQ-032 Bytes AA BB CC DD EE, rx_last on EE -> writes 0xDDCCBBAA@0, 0x000000EE@1; start high; word_count=2.
REQ-033 rx_valid held with byte 11 during WRITE cycle -> rx_ready=0 in WRITE, 11 accepted next cycle, lands in bits [7:0] of the next word exactly once.
REQ-034 ADDR_W=2, 17 bytes streamed -> four writes @0..3, 17th byte accepted, overflow=1, state ERR, start stays 0.
REQ-035 reset pulsed low after 6 bytes -> start=0, word_count=0, imem_we=0 at once; a fresh 4-byte load with rx_last then writes @0 and asserts start.
REQ-036 Bytes offered after start=1 -> rx_ready=0, no imem_we, word_count unchanged.

Source files
------------

// File: rtl/prog_loader.sv
// Byte-stream program loader: packs incoming bytes little-endian into 32-bit
// words, writes them to instruction memory, then releases the processor.
module prog_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_last,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              start,
  output logic              busy,
  output logic [ADDR_W:0]   word_count,
  output logic              overflow
);

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, RUN, ERR} state_t;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_t      state;
  logic [1:0]  byte_cnt;
  logic [31:0] asm_word;
  logic [31:0] next_word;
  logic        last_word;
  logic        accept;
  logic        full;

  assign accept = rx_valid && rx_ready;
  assign full   = (word_count == DEPTH);

  // Upper lanes of asm_word are still zero, so an early close is zero-filled.
  always_comb begin
    next_word = asm_word;
    next_word[{byte_cnt, 3'b000} +: 8] = rx_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      asm_word   <= '0;
      last_word  <= 1'b0;
      rx_ready   <= 1'b1;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      start      <= 1'b0;
      busy       <= 1'b0;
      word_count <= '0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE, LOAD: begin
          if (accept) begin
            if (full) begin
              state    <= ERR;
              overflow <= 1'b1;
              rx_ready <= 1'b0;
              busy     <= 1'b0;
            end else if (rx_last || byte_cnt == 2'd3) begin
              state      <= WRITE;
              rx_ready   <= 1'b0;
              busy       <= 1'b1;
              imem_we    <= 1'b1;
              imem_addr  <= word_count[ADDR_W-1:0];
              imem_wdata <= next_word;
              asm_word   <= next_word;
              last_word  <= rx_last;
            end else begin
              state    <= LOAD;
              busy     <= 1'b1;
              asm_word <= next_word;
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
        WRITE: begin
          imem_we    <= 1'b0;
          imem_addr  <= '0;
          imem_wdata <= '0;
          word_count <= word_count + (ADDR_W+1)'(1);
          asm_word   <= '0;
          byte_cnt   <= '0;
          if (last_word) begin
            state <= RUN;
            start <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state    <= LOAD;
            rx_ready <= 1'b1;
          end
        end
        RUN, ERR: begin
          state <= state;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: a byte/word-level model predicts every
// output each cycle; literal expectations pin the model on directed vectors.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_last = 1'b0;
  logic       sel = 1'b0;

  logic        o1_ready, o1_we, o1_start, o1_busy, o1_ovf;
  logic [7:0]  o1_addr;
  logic [31:0] o1_data;
  logic [8:0]  o1_wc;
  logic        o2_ready, o2_we, o2_start, o2_busy, o2_ovf;
  logic [1:0]  o2_addr;
  logic [31:0] o2_data;
  logic [2:0]  o2_wc;

  always #5 clk = ~clk;

  prog_loader #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_last(rx_last),
    .rx_ready(o1_ready), .imem_we(o1_we), .imem_addr(o1_addr), .imem_wdata(o1_data),
    .start(o1_start), .busy(o1_busy), .word_count(o1_wc), .overflow(o1_ovf));

  prog_loader #(.ADDR_W(2)) dut2 (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_last(rx_last),
    .rx_ready(o2_ready), .imem_we(o2_we), .imem_addr(o2_addr), .imem_wdata(o2_data),
    .start(o2_start), .busy(o2_busy), .word_count(o2_wc), .overflow(o2_ovf));

  logic        a_ready, a_we, a_start, a_busy, a_ovf;
  logic [7:0]  a_addr;
  logic [31:0] a_data;
  logic [8:0]  a_wc;

  always_comb begin
    a_ready = sel ? o2_ready : o1_ready;
    a_we    = sel ? o2_we    : o1_we;
    a_start = sel ? o2_start : o1_start;
    a_busy  = sel ? o2_busy  : o1_busy;
    a_ovf   = sel ? o2_ovf   : o1_ovf;
    a_addr  = sel ? {6'b0, o2_addr} : o1_addr;
    a_data  = sel ? o2_data  : o1_data;
    a_wc    = sel ? {6'b0, o2_wc} : o1_wc;
  end

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: bytes of the open word, a pending write, and run/error flags.
  logic [7:0]  mbytes[$];
  int unsigned mwc;
  bit          pend, plast, done, err, started;
  logic [31:0] pdata;
  int unsigned paddr;
  logic [39:0] wlog[$];

  function automatic int unsigned depth();
    return sel ? 4 : 256;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      mbytes.delete();
      mwc = 0; pend = 0; plast = 0; done = 0; err = 0; started = 0;
      pdata = '0; paddr = 0;
    end
    chk("rx_ready", 32'(a_ready), 32'(!pend && !done && !err));
    chk("imem_we", 32'(a_we), 32'(pend));
    chk("imem_addr", 32'(a_addr), pend ? paddr : 0);
    chk("imem_wdata", a_data, pend ? pdata : 32'h0);
    chk("start", 32'(a_start), 32'(done));
    chk("busy", 32'(a_busy), 32'(started && !done && !err));
    chk("word_count", 32'(a_wc), mwc);
    chk("overflow", 32'(a_ovf), 32'(err));
    if (a_we) wlog.push_back({a_addr, a_data});
    if (reset) begin
      if (pend) begin
        pend = 0;
        mwc++;
        if (plast) done = 1;
      end else if (!done && !err && rx_valid) begin
        started = 1;
        if (mwc == depth()) err = 1;
        else begin
          mbytes.push_back(rx_data);
          if (rx_last || mbytes.size() == 4) begin
            pdata = '0;
            foreach (mbytes[i]) pdata = pdata | (32'(mbytes[i]) << (8 * i));
            pend = 1;
            paddr = mwc % depth();
            plast = rx_last;
            mbytes.delete();
          end
        end
      end
    end
  end

  task automatic do_reset(input logic s);
    reset = 1'b0;
    rx_valid = 1'b0;
    rx_last = 1'b0;
    sel = s;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    wlog.delete();
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    bit ok;
    ok = 0;
    rx_valid = 1'b1;
    rx_data = d;
    rx_last = l;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (a_ready) ok = 1;
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL handshake: byte 0x%02h not accepted, expected acceptance", d);
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_log(input int idx, input logic [7:0] addr, input logic [31:0] data);
    if (idx < wlog.size()) begin
      chk("log_addr", 32'(wlog[idx][39:32]), 32'(addr));
      chk("log_data", wlog[idx][31:0], data);
    end else begin
      chk("log_present", 32'(wlog.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    // Reset state with no clock activity beyond reset hold.
    do_reset(1'b0);
    chk("rst_ready", 32'(o1_ready), 32'd1);
    chk("rst_wc", 32'(o1_wc), 32'd0);

    // Eight bytes, gapless, last on 08.
    for (int i = 1; i <= 8; i++) send(8'(i), i == 8);
    idle(4);
    chk("s1_nwrites", wlog.size(), 2);
    chk_log(0, 8'd0, 32'h04030201);
    chk_log(1, 8'd1, 32'h08070605);
    chk("s1_start", 32'(o1_start), 32'd1);
    chk("s1_wc", 32'(o1_wc), 32'd2);

    // Partial final word is zero-filled.
    do_reset(1'b0);
    send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0); send(8'hDD, 0); send(8'hEE, 1);
    idle(4);
    chk("s2_nwrites", wlog.size(), 2);
    chk_log(0, 8'd0, 32'hDDCCBBAA);
    chk_log(1, 8'd1, 32'h000000EE);
    chk("s2_start", 32'(o1_start), 32'd1);

    // Byte held across WRITE lands once in the next word's low lane.
    do_reset(1'b0);
    send(8'h21, 0); send(8'h22, 0); send(8'h23, 0); send(8'h24, 0);
    send(8'h11, 0); send(8'h12, 1);
    idle(4);
    chk("s3_nwrites", wlog.size(), 2);
    chk_log(0, 8'd0, 32'h24232221);
    chk_log(1, 8'd1, 32'h00001211);

    // Bytes offered while running are ignored.
    rx_valid = 1'b1; rx_data = 8'h99;
    idle(5);
    rx_valid = 1'b0;
    idle(2);
    chk("s4_nwrites", wlog.size(), 2);
    chk("s4_wc", 32'(o1_wc), 32'd2);
    chk("s4_start", 32'(o1_start), 32'd1);

    // Single byte with rx_last closes a word immediately.
    do_reset(1'b0);
    send(8'h5A, 1);
    idle(4);
    chk_log(0, 8'd0, 32'h0000005A);
    chk("s5_start", 32'(o1_start), 32'd1);

    // Reset mid-load clears at once; a fresh load starts from address 0.
    do_reset(1'b0);
    for (int i = 1; i <= 6; i++) send(8'(8'h40 + i), 0);
    reset = 1'b0;
    #1;
    chk("s6_rst_start", 32'(o1_start), 32'd0);
    chk("s6_rst_wc", 32'(o1_wc), 32'd0);
    chk("s6_rst_we", 32'(o1_we), 32'd0);
    do_reset(1'b0);
    send(8'h31, 0); send(8'h32, 0); send(8'h33, 0); send(8'h34, 1);
    idle(4);
    chk("s6_nwrites", wlog.size(), 1);
    chk_log(0, 8'd0, 32'h34333231);
    chk("s6_start", 32'(o1_start), 32'd1);

    // Overflow on a four-word memory.
    do_reset(1'b1);
    for (int i = 1; i <= 17; i++) send(8'(i), 0);
    idle(4);
    chk("s7_nwrites", wlog.size(), 4);
    chk_log(0, 8'd0, 32'h04030201);
    chk_log(3, 8'd3, 32'h100F0E0D);
    chk("s7_ovf", 32'(o2_ovf), 32'd1);
    chk("s7_start", 32'(o2_start), 32'd0);
    chk("s7_wc", 32'(o2_wc), 32'd4);
    chk("s7_ready", 32'(o2_ready), 32'd0);
    chk("s7_busy", 32'(o2_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
